multicycle_control_unit: RTL
============================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL expose parameter MAX_WAIT, default 15: max cycles a memory state waits for mem_ready before timeout, range 1..255.
REQ-002 SHALL expose parameter WAIT_W, default 8: width of the wait counter, at least clog2(MAX_WAIT+1).
REQ-003 SHALL have ports: clk in 1 system clock; rst_n in 1 reset (one clock; reset synchronous, active-low).
REQ-004 SHALL have inputs: opcode 7, func3 3, func7_5 1, zero 1 (ALU zero flag), mem_ready 1 (memory completes the access this cycle).
REQ-005 SHALL have outputs: mem_req 1, AdrSrc 1 (0 PC, 1 ALUOut), IRWrite 1, PCWrite 1, MemWrite 1, RegWrite 1.
REQ-006 SHALL have outputs: ResultSrc 2 (00 ALUOut, 01 data, 10 ALUResult), ALUSrcA 2 (00 PC, 01 OldPC, 10 RD1, 11 zero), ALUSrcB 2 (00 RD2, 01 imm, 10 const 4).
REQ-007 SHALL have outputs: ImmSrc 3 (000 I, 001 S, 010 B, 011 J, 100 U), ALUControl 3, state 4 (debug), illegal 1, mem_err 1.

Function
REQ-008 SHALL be a Moore FSM. Encodings: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 JAL=10 UTYPE=11.
REQ-009 Transitions: FETCH->DECODE on mem_ready only. DECODE dispatches on opcode: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; else->FETCH.
REQ-010 Transitions: MEMADR->MEMREAD (opcode[5]=0) or MEMWRITE (opcode[5]=1); MEMREAD->MEMWB on mem_ready; MEMWRITE->FETCH on mem_ready; MEMWB, BRANCH->FETCH; EXECR, EXECI, JAL, UTYPE->ALUWB; ALUWB->FETCH.
REQ-011 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add; IRWrite=PCWrite=mem_ready.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add. MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=001 if opcode[5] else 000.
REQ-013 MEMREAD: mem_req=1, AdrSrc=1. MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 held until the ready cycle. MEMWB: ResultSrc=01, RegWrite=1.
REQ-014 EXECR: ALUSrcA=10, ALUSrcB=00, R/I ALU decode. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, R/I ALU decode. ALUWB: ResultSrc=00, RegWrite=1.
REQ-015 BRANCH: ALUSrcA=10, ALUSrcB=00, subtract, ResultSrc=00; PCWrite=(zero XOR func3[0]), giving beq/bne.
REQ-016 JAL: ALUSrcA=01, ALUSrcB=10, ImmSrc=011, add, ResultSrc=00, PCWrite=1.
REQ-017 ALU decode: add=000, sub=001, and=010, or=011, slt=101, xor=110, srl=111.
REQ-018 ALU decode by func3: 000 gives sub only if opcode[5] AND func7_5, else add; 010 slt; 100 xor; 101 srl; 110 or; 111 and; other values give add.
REQ-019 Every output not listed for a state SHALL be 0, except ImmSrc=000; no X on any output in any state.
REQ-020 Wait counter: clears on entry to each of FETCH, MEMREAD and MEMWRITE, and increments each cycle in that state without mem_ready.
REQ-021 Timeout: when the counter reaches MAX_WAIT without mem_ready, mem_err pulses 1 cycle and the FSM goes to FETCH; IRWrite, PCWrite and RegWrite stay 0 for that access.
REQ-022 mem_ready on the same cycle the counter reaches MAX_WAIT SHALL count as success: no mem_err.
REQ-023 illegal SHALL pulse 1 cycle in DECODE for an unsupported opcode; no write strobe is asserted for that instruction.
REQ-024 mem_ready outside FETCH, MEMREAD and MEMWRITE SHALL be ignored.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force state FETCH and clear the wait counter, illegal and mem_err, overriding any state including a pending memory wait.
REQ-026 While rst_n=0, outputs SHALL be the FETCH values with IRWrite=PCWrite=mem_req=0; the first fetch starts on the first edge after release.

Configuration
REQ-027 Macro MCU_UTYPE_EN defined: DECODE sends 0110111 (lui) and 0010111 (auipc) to UTYPE.
REQ-028 UTYPE drives ImmSrc=100, ALUSrcB=01, add, with ALUSrcA=11 for lui and 01 for auipc.
REQ-029 Macro MCU_UTYPE_EN undefined: both opcodes are illegal (REQ-023) and encoding 11 is unreachable.

Verification
REQ-030 lw (0000011), mem_ready=1 every memory cycle -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; 5 cycles total.
REQ-031 sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite stays 0.
REQ-032 bne (func3=001) with zero=0 -> PCWrite=1 in BRANCH, ALUControl=001; repeat with zero=1 -> PCWrite=0.
REQ-033 R-type sub (func3=000, func7_5=1) -> ALUControl=001 in EXECR; addi with func7_5=1 -> ALUControl=000.
REQ-034 FETCH with mem_ready stuck 0 (MAX_WAIT=15) -> mem_err pulses once after 15 cycles; IRWrite never 1; FSM re-enters FETCH.
REQ-035 rst_n low during a MEMREAD wait -> state=0 on the next edge; opcode 0110111 without MCU_UTYPE_EN -> illegal pulse, back to FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control unit: Moore FSM with memory wait counting and timeout.
// Optional feature: define MCU_UTYPE_EN to execute lui/auipc through the UTYPE state.
module multicycle_control_unit #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef MCU_UTYPE_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_UTYPE    = 4'd11
  } state_t;

  state_t            cur_st;
  state_t            out_st;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              timeout;
  logic              supported;
  logic [2:0]        alu_ri;

  // Timeout only fires when the last allowed wait cycle also lacks mem_ready.
  always_comb begin
    waiting = (cur_st == S_FETCH) || (cur_st == S_MEMREAD) || (cur_st == S_MEMWRITE);
    timeout = waiting && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    supported = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL: supported = 1'b1;
`ifdef MCU_UTYPE_EN
      OP_LUI, OP_AUIPC: supported = 1'b1;
`endif
      default: supported = 1'b0;
    endcase
  end

  // R/I ALU decode; func7_5 selects subtract only for R-type.
  always_comb begin
    alu_ri = ALU_ADD;
    case (func3)
      3'b000:  alu_ri = (opcode[5] && func7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_ri = ALU_SLT;
      3'b100:  alu_ri = ALU_XOR;
      3'b101:  alu_ri = ALU_SRL;
      3'b110:  alu_ri = ALU_OR;
      3'b111:  alu_ri = ALU_AND;
      default: alu_ri = ALU_ADD;
    endcase
  end

  // Any transition clears the wait counter; staying in a wait state counts up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_st   <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur_st)
        S_FETCH: begin
          if (mem_ready)     cur_st   <= S_DECODE;
          else if (!timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: cur_st <= S_MEMADR;
            OP_R:              cur_st <= S_EXECR;
            OP_I:              cur_st <= S_EXECI;
            OP_BR:             cur_st <= S_BRANCH;
            OP_JAL:            cur_st <= S_JAL;
`ifdef MCU_UTYPE_EN
            OP_LUI, OP_AUIPC:  cur_st <= S_UTYPE;
`endif
            default:           cur_st <= S_FETCH;
          endcase
        end
        S_MEMADR: cur_st <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD: begin
          if (mem_ready)    cur_st   <= S_MEMWB;
          else if (timeout) cur_st   <= S_FETCH;
          else              wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_MEMWRITE: begin
          if (mem_ready || timeout) cur_st   <= S_FETCH;
          else                      wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_EXECR, S_EXECI, S_JAL, S_UTYPE: cur_st <= S_ALUWB;
        default: cur_st <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; reset shows quiet FETCH values.
  always_comb begin
    out_st     = rst_n ? cur_st : S_FETCH;
    state      = out_st;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    mem_err    = rst_n && timeout;
    case (out_st)
      S_FETCH: begin
        mem_req   = rst_n;
        IRWrite   = rst_n && mem_ready;
        PCWrite   = rst_n && mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
        illegal = !supported;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = opcode[5] ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_ri;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_ri;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = zero ^ func3[0];
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ImmSrc  = 3'b011;
        PCWrite = 1'b1;
      end
      S_UTYPE: begin
        ALUSrcA = opcode[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
      end
      default: ;
    endcase
  end

endmodule
